// File: rtl/shift_serializer_if.sv
// Parallel-in / serial-out handshake bundle for shift_serializer.
// The upstream side presents words on din/din_valid and sees din_ready.
// The downstream side sees sout/sout_valid/sout_last and drives sout_ready.
interface shift_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             sout_ready;
   logic             sout_last;

   // Environment side: produces words, consumes serial bits.
   modport master (
      output din,
      output din_valid,
      output sout_ready,
      input  din_ready,
      input  sout,
      input  sout_valid,
      input  sout_last
   );

   // Serializer side.
   modport slave (
      input  din,
      input  din_valid,
      input  sout_ready,
      output din_ready,
      output sout,
      output sout_valid,
      output sout_last
   );
endinterface

// File: rtl/shift_serializer.sv
// LSB-first parallel-to-serial converter with valid/ready on both sides.
// A word is loaded into shreg and shifted out one bit per accepted transfer.
// The next word may be loaded on the same edge as the final bit of the
// current word, so back-to-back words stream with no bubble.
module shift_serializer #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   shift_serializer_if.slave  bus
);

   // Counter wide enough to index bits 0..WIDTH-1.
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_reg;
   state_t             state_next;
   logic [WIDTH-1:0]   shreg_reg;
   logic [WIDTH-1:0]   shreg_next;
   logic [CNT_W-1:0]   cnt_reg;
   logic [CNT_W-1:0]   cnt_next;

   logic               sout_valid;
   logic               sout_bit;
   logic               sout_last;
   logic               din_ready;
   logic               load;
   logic               xfer;

   // State register: reset discards any partially serialized word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         shreg_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shreg_reg <= shreg_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next-state and output decode; a load takes priority over the
   // final-bit return to IDLE so consecutive words run without a gap.
   always_comb begin
      state_next = state_reg;
      shreg_next = shreg_reg;
      cnt_next   = cnt_reg;
      sout_valid = 1'b0;
      sout_bit   = 1'b0;
      sout_last  = 1'b0;
      din_ready  = 1'b0;
      load       = 1'b0;
      xfer       = 1'b0;

      case (state_reg)
         IDLE: begin
            din_ready = 1'b1;
         end
         SHIFT: begin
            sout_valid = 1'b1;
            sout_bit   = shreg_reg[0];
            sout_last  = (cnt_reg == LAST_CNT);
            // Only the final bit frees the register for a new word.
            din_ready  = sout_last && bus.sout_ready;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      xfer = sout_valid && bus.sout_ready;
      load = bus.din_valid && din_ready;

      if (xfer) begin
         if (sout_last) begin
            state_next = IDLE;
            cnt_next   = '0;
         end else begin
            shreg_next = {1'b0, shreg_reg[WIDTH-1:1]};
            cnt_next   = cnt_reg + CNT_W'(1);
         end
      end

      if (load) begin
         shreg_next = bus.din;
         cnt_next   = '0;
         state_next = SHIFT;
      end
   end

   assign bus.din_ready  = din_ready;
   assign bus.sout       = sout_bit;
   assign bus.sout_valid = sout_valid;
   assign bus.sout_last  = sout_last;

endmodule

// File: tb/tb_shift_serializer.sv
// Directed bench for shift_serializer (WIDTH=8 and WIDTH=2 instances).
// Stimulus pushes the expected {last, bit} stream into a queue when a word
// is issued; monitors pop and compare on every accepted serial transfer.
module tb_shift_serializer;

   logic clk;
   logic rst_n;

   shift_serializer_if #(.WIDTH(8)) b8 ();
   shift_serializer_if #(.WIDTH(2)) b2 ();

   shift_serializer #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b8.slave)
   );

   shift_serializer #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b2.slave)
   );

   int checks = 0;
   int passes = 0;

   logic [1:0] q8[$];   // {last, bit}
   logic [1:0] q2[$];

   int cur_run = 0;     // consecutive sout_valid cycles on the 8-bit DUT
   int max_run = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst_n && b8.sout_valid) begin
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
      end else begin
         cur_run = 0;
      end
      if (rst_n && b8.sout_valid && b8.sout_ready) begin
         if (q8.size() == 0) begin
            checks++;
            $display("FAIL w8_unexpected: got sout=%0b with nothing expected at %0t", b8.sout, $time);
         end else begin
            e = q8.pop_front();
            chk("w8_sout", 32'(b8.sout), 32'(e[0]));
            chk("w8_last", 32'(b8.sout_last), 32'(e[1]));
         end
      end
   end

   // Monitor for the 2-bit instance.
   always @(negedge clk) begin
      logic [1:0] e;
      if (rst_n && b2.sout_valid && b2.sout_ready) begin
         if (q2.size() == 0) begin
            checks++;
            $display("FAIL w2_unexpected: got sout=%0b with nothing expected at %0t", b2.sout, $time);
         end else begin
            e = q2.pop_front();
            chk("w2_sout", 32'(b2.sout), 32'(e[0]));
            chk("w2_last", 32'(b2.sout_last), 32'(e[1]));
         end
      end
   end

   // Offer a word on the 8-bit DUT until accepted; returns one tick after the load edge.
   task automatic send8(input logic [7:0] w, output int rejects, output logic last_at_accept);
      bit ok = 0;
      for (int i = 0; i < 8; i++) q8.push_back({(i == 7), w[i]});
      b8.din       = w;
      b8.din_valid = 1'b1;
      rejects        = 0;
      last_at_accept = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (b8.din_ready) begin
            ok = 1;
            last_at_accept = b8.sout_last;
            break;
         end
         rejects++;
      end
      chk("w8_accept_in_time", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      b8.din_valid = 1'b0;
   endtask

   // Wait for the expected stream to drain and the DUT to go idle.
   task automatic drain8(input string name);
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (q8.size() == 0 && !b8.sout_valid) begin
            ok = 1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int   rej;
      logic lst;
      bit   ok;

      rst_n = 1'b0;
      b8.din = '0; b8.din_valid = 1'b0; b8.sout_ready = 1'b1;
      b2.din = '0; b2.din_valid = 1'b0; b2.sout_ready = 1'b1;

      // Reset state.
      #2;
      chk("rst_din_ready", 32'(b8.din_ready), 32'd1);
      chk("rst_sout_valid", 32'(b8.sout_valid), 32'd0);
      chk("rst_sout", 32'(b8.sout), 32'd0);
      chk("rst_sout_last", 32'(b8.sout_last), 32'd0);
      chk("rst_w2_sout_valid", 32'(b2.sout_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word 8'hA5: bit 0 visible right after the load edge, 8 valid cycles.
      max_run = 0;
      send8(8'hA5, rej, lst);
      chk("single_first_valid", 32'(b8.sout_valid), 32'd1);
      chk("single_first_bit", 32'(b8.sout), 32'd1);
      chk("single_reject_idle", 32'(rej), 32'd0);
      drain8("single_drain");
      chk("single_run_len", 32'(max_run), 32'd8);
      chk("single_idle_after", 32'(b8.sout_valid), 32'd0);

      // Back-to-back 8'hA5 then 8'h3C: 16 contiguous cycles, second load on the last bit.
      max_run = 0;
      send8(8'hA5, rej, lst);
      send8(8'h3C, rej, lst);
      chk("b2b_accept_on_last", 32'(lst), 32'd1);
      chk("b2b_rejects", 32'(rej), 32'd7);
      drain8("b2b_drain");
      chk("b2b_run_len", 32'(max_run), 32'd16);

      // Backpressure at cnt=2 for 3 cycles: bit 2 of A5 (=1) holds.
      max_run = 0;
      send8(8'hA5, rej, lst);
      repeat (2) @(posedge clk);
      #1;
      b8.sout_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("bp_hold_bit", 32'(b8.sout), 32'd1);
         chk("bp_hold_valid", 32'(b8.sout_valid), 32'd1);
         chk("bp_hold_last", 32'(b8.sout_last), 32'd0);
         chk("bp_din_ready", 32'(b8.din_ready), 32'd0);
      end
      @(posedge clk);
      #1;
      b8.sout_ready = 1'b1;
      drain8("bp_drain");
      chk("bp_run_len", 32'(max_run), 32'd11);

      // Busy reject: 8'hFF offered at cnt=3 of 8'h00, accepted only on the final bit.
      max_run = 0;
      send8(8'h00, rej, lst);
      repeat (3) @(posedge clk);
      #1;
      send8(8'hFF, rej, lst);
      chk("busy_rejects", 32'(rej), 32'd4);
      chk("busy_accept_on_last", 32'(lst), 32'd1);
      drain8("busy_drain");
      chk("busy_run_len", 32'(max_run), 32'd16);

      // Reset mid-word at cnt=4 of 8'hA5, inputs ignored while held.
      send8(8'hA5, rej, lst);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(b8.sout_valid), 32'd0);
      chk("mid_rst_din_ready", 32'(b8.din_ready), 32'd1);
      chk("mid_rst_sout", 32'(b8.sout), 32'd0);
      chk("mid_rst_last", 32'(b8.sout_last), 32'd0);
      q8.delete();
      b8.din = 8'hFF;
      b8.din_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("in_rst_no_load", 32'(b8.sout_valid), 32'd0);
      b8.din_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_idle", 32'(b8.sout_valid), 32'd0);
      max_run = 0;
      send8(8'h0F, rej, lst);
      drain8("post_rst_drain");
      chk("post_rst_run_len", 32'(max_run), 32'd8);

      // WIDTH=2 build: 2'b10 -> 0 then 1 (last).
      q2.push_back(2'b00);
      q2.push_back(2'b11);
      b2.din = 2'b10;
      b2.din_valid = 1'b1;
      @(negedge clk);
      chk("w2_ready_idle", 32'(b2.din_ready), 32'd1);
      @(posedge clk);
      #1;
      b2.din_valid = 1'b0;
      chk("w2_first_valid", 32'(b2.sout_valid), 32'd1);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (q2.size() == 0 && !b2.sout_valid) begin
            ok = 1;
            break;
         end
      end
      chk("w2_drain", 32'(ok), 32'd1);

      chk("q8_empty", 32'(q8.size()), 32'd0);
      chk("q2_empty", 32'(q2.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/shift_serializer.md
SHIFT_SERIALIZER -- requirements
Module: shift_serializer

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, legal range 2..32, giving the parallel word width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port din, input, WIDTH bits: the parallel word to serialize.
REQ-005 The block SHALL have port din_valid, input, 1 bit: din holds a word to load.
REQ-006 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-007 The block SHALL have port sout, output, 1 bit: the current serial bit, LSB first.
REQ-008 The block SHALL have port sout_valid, output, 1 bit: sout holds a valid bit.
REQ-009 The block SHALL have port sout_ready, input, 1 bit: the downstream consumer takes sout this cycle.
REQ-010 The block SHALL have port sout_last, output, 1 bit: sout is bit WIDTH-1 of the current word.

Function
REQ-011 The block SHALL implement a two-state FSM with states IDLE and SHIFT, a WIDTH-bit shift register shreg, and a bit counter cnt of width clog2(WIDTH).
REQ-012 In IDLE, the block SHALL drive sout_valid=0, sout=0 and sout_last=0.
REQ-013 In SHIFT, the block SHALL drive sout_valid=1, sout=shreg[0] and sout_last=(cnt==WIDTH-1).
REQ-014 The block SHALL generate din_ready combinationally as (state==IDLE) OR (state==SHIFT AND sout_last AND sout_ready).
REQ-015 A load SHALL occur when din_valid AND din_ready: shreg<=din, cnt<=0, state<=SHIFT.
REQ-016 A bit transfer SHALL occur when sout_valid AND sout_ready.
REQ-017 On a non-final bit transfer, the block SHALL shift shreg right by one (MSB filled with 0) and set cnt<=cnt+1.
REQ-018 On a final bit transfer (sout_last=1) with a simultaneous load, the block SHALL reload per REQ-015 and stay in SHIFT, with no idle cycle between words.
REQ-019 On a final bit transfer with no load, the block SHALL go to IDLE and clear cnt.
REQ-020 While sout_valid=1 and sout_ready=0, the block SHALL hold sout, sout_last, shreg and cnt stable, so no bit is lost or duplicated.
REQ-021 While in SHIFT and not on a final bit transfer, the block SHALL ignore din_valid (din_ready=0); the upstream stage holds din until accepted.
REQ-022 Latency SHALL be one cycle: for a word loaded at edge N, bit 0 appears on sout after edge N, and the final bit is sout_last in cycle N+WIDTH when sout_ready is held high.
REQ-023 The block SHALL have no other outputs and no internal storage beyond shreg, cnt and the state.

Reset
REQ-024 While rst_n=0, asynchronously and regardless of clk, the block SHALL hold state=IDLE, shreg=0 and cnt=0; outputs are then sout=0, sout_valid=0, sout_last=0 and din_ready=1.
REQ-025 While rst_n=0, the block SHALL ignore all inputs; no load occurs on an edge while rst_n is low.
REQ-026 Reset asserted mid-word SHALL discard the partial word; after release, the first accepted word serializes from bit 0.

Verification
REQ-027 Single word: din=8'hA5 loaded, sout_ready=1 -> sout sequence 1,0,1,0,0,1,0,1 over 8 consecutive cycles, sout_last only on the 8th, then sout_valid=0.
REQ-028 Back-to-back: 8'hA5 then 8'h3C presented with din_valid held -> 16 contiguous sout_valid cycles; the second word is accepted in the cycle sout_last=1; bits are 10100101 then 00111100.
REQ-029 Backpressure: word 8'hA5, sout_ready=0 for 3 cycles while cnt=2 -> sout holds 1 for those 3 cycles; full sequence unchanged, total 11 cycles.
REQ-030 Busy reject: din_valid=1 with 8'hFF while cnt=3 of 8'h00 -> din_ready=0 until the final bit; 8'hFF is loaded only at the final transfer; output is 8 zeros then 8 ones.
REQ-031 Reset mid-word: rst_n low at cnt=4 of 8'hA5 -> sout_valid=0 immediately (asynchronous); after release, 8'h0F serializes as 1,1,1,1,0,0,0,0.
REQ-032 WIDTH=2 build: din=2'b10 -> sout 0 then 1, with sout_last on the second bit.
